// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state type, default timing constants, command bytes and parity helper for the PS/2 host transmitter
package ps2_pkg;
  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    RTS,
    SHIFT,
    WAIT_IDLE
  } ps2_state_e;
  localparam int PS2_INHIBIT_CYCLES_DEF = 5000;
  localparam int PS2_TIMEOUT_CYCLES_DEF = 750000;
  localparam logic [3:0] PS2_PARITY_FALL = 4'd9;
  localparam logic [3:0] PS2_STOP_FALL = 4'd10;
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET = 8'hFF;
  function automatic logic ps2_odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction
endpackage

// File: rtl/ps2_host_tx_fall_detect.sv
// ps2_fall_detect: registered copy of the synchronized PS/2 clock and a one-cycle falling-edge pulse
//   clk_i  system clock        rst_ni async active-low reset
//   ps2c_i synchronized ps2c   fall_o high for the cycle ps2c is first seen low
module ps2_fall_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ps2c_i,
  output logic fall_o
);
  logic ps2c_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ps2c_q <= 1'b1;
    else ps2c_q <= ps2c_i;
  end
  assign fall_o = ps2c_q & ~ps2c_i;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter sending one command byte through open-drain pull-low enables
//   CLOCK_50 clock, RESET async active-low; TX_DATA/TX_START request a byte (accepted only when idle)
//   ps2c/ps2d synchronized bus inputs; PS2_CLK_LOW/PS2_DAT_LOW pull the bus lines low when 1
//   TX_BUSY/RX_INHIBIT high while a frame is in flight; TX_DONE/TX_ERROR one-cycle completion pulses
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_DEF
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [7:0] TX_DATA,
  input  logic       TX_START,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic       PS2_CLK_LOW,
  output logic       PS2_DAT_LOW,
  output logic       TX_BUSY,
  output logic       TX_DONE,
  output logic       TX_ERROR,
  output logic       RX_INHIBIT
);
  localparam int IW = $clog2(INHIBIT_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [IW-1:0] INH_MAX = IW'(INHIBIT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);
  ps2_state_e state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [IW-1:0] inh_q, inh_d, inh_inc;
  logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
  logic [3:0] n_q, n_d;
  logic done_q, done_d, err_q, err_d;
  logic fall, tmo_hit, shift_bit;
  ps2_fall_detect u_fall (
    .clk_i (CLOCK_50),
    .rst_ni(RESET),
    .ps2c_i(ps2c),
    .fall_o(fall)
  );
  assign inh_inc = (inh_q == INH_MAX) ? inh_q : inh_q + IW'(1);
  assign tmo_inc = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TW'(1);
  assign tmo_hit = tmo_q >= TMO_LAST;
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    inh_d = inh_q;
    tmo_d = tmo_q;
    n_d = n_q;
    done_d = 1'b0;
    err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (TX_START) begin
          data_d = TX_DATA;
          inh_d = '0;
          tmo_d = '0;
          n_d = '0;
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        inh_d = inh_inc;
        state_d = (inh_q >= INH_LAST) ? START : INHIBIT;
      end
      START: begin
        tmo_d = '0;
        state_d = RTS;
      end
      RTS, SHIFT, WAIT_IDLE: begin
        tmo_d = tmo_inc;
        // the timeout wins over any bus event seen in the same cycle
        if (tmo_hit) begin
          err_d = 1'b1;
          state_d = IDLE;
        end else if (state_q == RTS) begin
          state_d = SHIFT;
        end else if (state_q == SHIFT) begin
          if (fall && n_q == PS2_STOP_FALL) begin
            err_d = ps2d;
            state_d = ps2d ? IDLE : WAIT_IDLE;
          end else if (fall) begin
            n_d = n_q + 4'd1;
          end
        end else if (ps2c && ps2d) begin
          done_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_50 or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      data_q <= '0;
      inh_q <= '0;
      tmo_q <= '0;
      n_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      inh_q <= inh_d;
      tmo_q <= tmo_d;
      n_q <= n_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  // n counts falls seen so far: n=0 still holds the start bit, 1..8 data LSB first, 9 parity, 10 stop (released)
  assign shift_bit = (n_q == PS2_PARITY_FALL) ? ps2_odd_parity(data_q) : data_q[3'(n_q - 4'd1)];
  assign PS2_DAT_LOW = (state_q == START || state_q == RTS) ? 1'b1 :
                       (state_q != SHIFT) ? 1'b0 :
                       (n_q == 4'd0) ? 1'b1 :
                       (n_q <= PS2_PARITY_FALL) ? ~shift_bit : 1'b0;
  assign PS2_CLK_LOW = (state_q == INHIBIT) || (state_q == START);
  assign TX_BUSY = state_q != IDLE;
  assign RX_INHIBIT = TX_BUSY;
  assign TX_DONE = done_q;
  assign TX_ERROR = err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench driving ps2_host_tx against an open-drain PS/2 device model
module tb_ps2_host_tx;
  import ps2_pkg::*;
  localparam int INH = 20;
  localparam int TMO = 2000;
  typedef struct {
    logic       err;
    logic       has_frame;
    logic [9:0] frame;
  } exp_t;
  logic CLOCK_50 = 1'b0;
  logic RESET = 1'b0;
  logic TX_START = 1'b0;
  logic [7:0] TX_DATA = '0;
  logic ps2c = 1'b1, ps2d = 1'b1, c_s1 = 1'b1, d_s1 = 1'b1;
  logic ps2c_pin, ps2d_pin;
  logic PS2_CLK_LOW, PS2_DAT_LOW, TX_BUSY, TX_DONE, TX_ERROR, RX_INHIBIT;
  logic dev_clk_low = 1'b0, dev_dat_low = 1'b0, dev_abort = 1'b0, prev_busy = 1'b0;
  int dev_mode = 0, dev_h = 40, dev_falls = 0;
  int pass_cnt = 0, total_cnt = 0;
  exp_t exp_q[$];
  logic [9:0] obs_q[$];
  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET      (RESET),
    .TX_DATA    (TX_DATA),
    .TX_START   (TX_START),
    .ps2c       (ps2c),
    .ps2d       (ps2d),
    .PS2_CLK_LOW(PS2_CLK_LOW),
    .PS2_DAT_LOW(PS2_DAT_LOW),
    .TX_BUSY    (TX_BUSY),
    .TX_DONE    (TX_DONE),
    .TX_ERROR   (TX_ERROR),
    .RX_INHIBIT (RX_INHIBIT)
  );
  always #10 CLOCK_50 = ~CLOCK_50;
  assign ps2c_pin = ~(PS2_CLK_LOW | dev_clk_low);
  assign ps2d_pin = ~(PS2_DAT_LOW | dev_dat_low);
  always @(posedge CLOCK_50) begin
    c_s1 <= ps2c_pin;
    ps2c <= c_s1;
    d_s1 <= ps2d_pin;
    ps2d <= d_s1;
  end
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", name, got, exp);
  endtask
  // wire frame as the device sees it: data LSB first, odd parity, stop bit 1
  function automatic logic [9:0] wire_frame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, 1'(ones % 2 == 0), b};
  endfunction
  task automatic dev_wait(input int n);
    for (int i = 0; i < n && !dev_abort; i++) @(negedge CLOCK_50);
  endtask
  // device model: clocks 10 bits in, samples on each rising edge, then acks (mode 0) or not (mode 1)
  task automatic run_frame();
    int h = dev_h;
    int mode = dev_mode;
    logic [9:0] bits = '0;
    dev_falls = 0;
    dev_wait(h);
    for (int k = 0; k < 10 && !dev_abort; k++) begin
      dev_clk_low = 1'b1;
      dev_falls++;
      dev_wait(h);
      dev_clk_low = 1'b0;
      bits[k] = ps2d_pin;
      dev_wait(h);
    end
    if (!dev_abort) begin
      obs_q.push_back(bits);
      dev_wait(h / 2);
      dev_dat_low = (mode == 1) ? 1'b0 : 1'b1;
      dev_wait(h / 2);
      dev_clk_low = 1'b1;
      dev_falls++;
      dev_wait(h);
      dev_clk_low = 1'b0;
      dev_wait(h / 2);
    end
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    dev_abort = 1'b0;
  endtask
  initial forever begin
    @(negedge CLOCK_50);
    if (RESET && PS2_DAT_LOW && !PS2_CLK_LOW) begin
      if (dev_mode == 2) while (PS2_DAT_LOW) @(negedge CLOCK_50);
      else run_frame();
    end
  end
  always @(negedge CLOCK_50) begin
    if (RESET && (TX_DONE || TX_ERROR)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'({TX_DONE, TX_ERROR}), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_kind", 32'({TX_DONE, TX_ERROR}), e.err ? 32'd1 : 32'd2);
        check("busy_at_pulse", 32'({TX_BUSY, RX_INHIBIT}), 32'd0);
        check("busy_before_pulse", 32'(prev_busy), 32'd1);
        if (e.has_frame) begin
          check("frame_observed", 32'(obs_q.size() > 0), 32'd1);
          if (obs_q.size() > 0) check("wire_frame", 32'(obs_q.pop_front()), 32'(e.frame));
        end
      end
    end
    prev_busy = TX_BUSY;
  end
  task automatic start_frame(input logic [7:0] b);
    int n = 0;
    TX_DATA = b;
    TX_START = 1'b1;
    @(negedge CLOCK_50);
    TX_START = 1'b0;
    TX_DATA = 8'($urandom);
    check("busy_after_accept", 32'({TX_BUSY, RX_INHIBIT}), 32'd3);
    while (PS2_CLK_LOW && n < 1000) begin
      n++;
      @(negedge CLOCK_50);
    end
    check("inhibit_len", n, INH + 1);
  endtask
  task automatic finish_frame(input bit poke, output int c);
    c = 0;
    while (!(TX_DONE || TX_ERROR) && c < 6000) begin
      TX_START = poke && c == 100;
      if (poke && c == 100) TX_DATA = 8'h55;
      @(negedge CLOCK_50);
      c++;
    end
    TX_START = 1'b0;
    check("frame_completes", 32'(c < 6000), 32'd1);
  endtask
  task automatic send(input logic [7:0] b, input int mode, input bit poke);
    exp_t e;
    int c;
    dev_mode = mode;
    dev_h = $urandom_range(30, 50);
    dev_falls = 0;
    e.err = mode != 0;
    e.has_frame = mode != 2;
    e.frame = wire_frame(b);
    exp_q.push_back(e);
    start_frame(b);
    finish_frame(poke, c);
    check("lines_released", 32'({PS2_CLK_LOW, PS2_DAT_LOW}), 32'd0);
    if (mode == 2) check("rts_to_timeout", c, TMO);
  endtask
  initial begin
    int c;
    repeat (3) @(negedge CLOCK_50);
    check("rst_clk_low", 32'(PS2_CLK_LOW), 32'd0);
    check("rst_dat_low", 32'(PS2_DAT_LOW), 32'd0);
    check("rst_busy", 32'({TX_BUSY, RX_INHIBIT}), 32'd0);
    check("rst_pulses", 32'({TX_DONE, TX_ERROR}), 32'd0);
    RESET = 1'b1;
    @(negedge CLOCK_50);
    send(PS2_CMD_SET_LEDS, 0, 1'b1);
    send(8'h01, 0, 1'b0);
    send(PS2_CMD_RESET, 0, 1'b0);
    send(8'($urandom), 2, 1'b0);
    send(8'($urandom), 1, 1'b0);
    dev_mode = 0;
    dev_h = 40;
    dev_falls = 0;
    start_frame(PS2_CMD_SET_LEDS);
    c = 0;
    while (dev_falls < 5 && c < 3000) begin
      @(negedge CLOCK_50);
      c++;
    end
    check("reached_bit4", 32'(dev_falls >= 5), 32'd1);
    repeat (8) @(negedge CLOCK_50);
    #1 RESET = 1'b0;
    #1;
    check("midrst_clk_low", 32'(PS2_CLK_LOW), 32'd0);
    check("midrst_dat_low", 32'(PS2_DAT_LOW), 32'd0);
    check("midrst_busy", 32'(TX_BUSY), 32'd0);
    check("midrst_rx_inhibit", 32'(RX_INHIBIT), 32'd0);
    dev_abort = 1'b1;
    repeat (4) @(negedge CLOCK_50);
    RESET = 1'b1;
    c = 0;
    while (dev_abort && c < 500) begin
      @(negedge CLOCK_50);
      c++;
    end
    check("device_recovered", 32'(dev_abort), 32'd0);
    repeat (10) @(negedge CLOCK_50);
    send(PS2_CMD_SET_LEDS, 0, 1'b0);
    for (int i = 0; i < 6; i++) send(8'($urandom), ($urandom_range(0, 3) == 0) ? 1 : 0, 1'b0);
    repeat (50) @(negedge CLOCK_50);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("frames_drained", 32'(obs_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required finished");
    $fatal(1);
  end
endmodule
